// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Schedules note-on / note-off events onto N_VOICES shared oscillator voices.
// Each accepted event is scanned against every voice, one voice per cycle,
// then committed. Note-on picks: retrigger (same note, ON or REL), else the
// lowest-index FREE voice, else the oldest REL voice, else the oldest ON voice.
// Note-off moves the lowest-index ON voice with a matching note into REL.
// REL voices stay enabled for RELEASE_TICKS sample ticks, then become FREE.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active high
//   sample_tick      1-cycle strobe per sample_clk rising edge (clk domain)
//   ev_valid         event present
//   ev_ready         allocator can accept an event
//   ev_note_on       1 = note-on, 0 = note-off
//   ev_note          note-id tag (only used to match note-off to note-on)
//   ev_freq          frequency for note-on
//   ev_velocity      velocity for note-on
//   panic            level; forces every voice FREE and drops in-flight event
//   voice_enable     per-voice oscillator enable (voice not FREE)
//   voice_env_reset  per-voice envelope reset, held until a sample tick passes
//   voice_freq       packed, voice i at [i*FREQ_W +: FREQ_W]
//   voice_velocity   packed, voice i at [i*VEL_W +: VEL_W]
//   voices_busy      registered count of voices not FREE
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int N_VOICES      = 4,
  parameter int FREQ_W        = 32,
  parameter int VEL_W         = 24,
  parameter int NOTE_W        = 7,
  parameter int RELEASE_TICKS = 4800
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_note_on,
  input  logic [NOTE_W-1:0]             ev_note,
  input  logic [FREQ_W-1:0]             ev_freq,
  input  logic [VEL_W-1:0]              ev_velocity,
  input  logic                          panic,
  output logic [N_VOICES-1:0]           voice_enable,
  output logic [N_VOICES-1:0]           voice_env_reset,
  output logic [N_VOICES*FREQ_W-1:0]    voice_freq,
  output logic [N_VOICES*VEL_W-1:0]     voice_velocity,
  output logic [$clog2(N_VOICES+1)-1:0] voices_busy
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int CNT_W = $clog2(N_VOICES + 1);
  localparam int REL_W = $clog2(RELEASE_TICKS + 1);
  localparam int AGE_W = 16;

  typedef enum logic [1:0] {V_FREE, V_ON, V_REL} voice_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} fsm_state_t;
  // Candidate classes in priority order; a lower value wins. C_NONE = not eligible.
  typedef enum logic [2:0] {C_NONE, C_RETRIG, C_FREE, C_REL, C_ON} cand_class_t;

  // Per-voice state
  voice_state_t      v_state [N_VOICES];
  logic [NOTE_W-1:0] v_note  [N_VOICES];
  logic [FREQ_W-1:0] v_freq  [N_VOICES];
  logic [VEL_W-1:0]  v_vel   [N_VOICES];
  logic [AGE_W-1:0]  v_age   [N_VOICES];
  logic [REL_W-1:0]  v_rel   [N_VOICES];

  // Sequencer state and latched event
  fsm_state_t        fsm;
  logic              ready_q;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  best_idx;
  cand_class_t       best_class;
  logic [AGE_W-1:0]  best_age;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [FREQ_W-1:0] ev_freq_q;
  logic [VEL_W-1:0]  ev_vel_q;

  cand_class_t       cand_class;
  logic              cand_better;
  logic [CNT_W-1:0]  busy_next;

  // ready_q tracks "back in IDLE with panic low at the last edge"; the live
  // panic/rst terms drop ready immediately without waiting for an edge.
  assign ev_ready = ready_q && !panic && !rst;

  // Classify the voice in the current scan slot and compare with the best so far.
  // NOTE: every signal written in an always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cand_class  = C_NONE;
    cand_better = 1'b0;
    if (ev_on_q) begin
      if (v_state[scan_idx] != V_FREE && v_note[scan_idx] == ev_note_q) cand_class = C_RETRIG;
      else if (v_state[scan_idx] == V_FREE)                             cand_class = C_FREE;
      else if (v_state[scan_idx] == V_REL)                              cand_class = C_REL;
      else                                                              cand_class = C_ON;
    end else if (v_state[scan_idx] == V_ON && v_note[scan_idx] == ev_note_q) begin
      cand_class = C_RETRIG;
    end
    // Equal classes keep the earlier (lower) index, except the steal classes
    // which prefer a strictly older voice.
    if (cand_class != C_NONE) begin
      if (best_class == C_NONE || cand_class < best_class)
        cand_better = 1'b1;
      else if (cand_class == best_class && (cand_class == C_REL || cand_class == C_ON) &&
               v_age[scan_idx] > best_age)
        cand_better = 1'b1;
    end
  end

  always_comb begin
    busy_next = '0;
    for (int i = 0; i < N_VOICES; i++)
      if (v_state[i] != V_FREE) busy_next = busy_next + CNT_W'(1);
  end

  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      voice_enable[i]                     = (v_state[i] != V_FREE);
      voice_freq[i*FREQ_W +: FREQ_W]      = v_freq[i];
      voice_velocity[i*VEL_W +: VEL_W]    = v_vel[i];
    end
  end

  // NOTE: the per-voice arrays are small register files, not RAM, so they are
  // reset explicitly; the outputs read them directly and must be 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm             <= S_IDLE;
      ready_q         <= 1'b1;
      scan_idx        <= '0;
      best_idx        <= '0;
      best_class      <= C_NONE;
      best_age        <= '0;
      ev_on_q         <= 1'b0;
      ev_note_q       <= '0;
      ev_freq_q       <= '0;
      ev_vel_q        <= '0;
      voices_busy     <= '0;
      voice_env_reset <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        v_state[i] <= V_FREE;
        v_note[i]  <= '0;
        v_freq[i]  <= '0;
        v_vel[i]   <= '0;
        v_age[i]   <= '0;
        v_rel[i]   <= '0;
      end
    end else begin
      voices_busy <= busy_next;

      if (panic) begin
        fsm             <= S_IDLE;
        ready_q         <= 1'b0;
        scan_idx        <= '0;
        best_class      <= C_NONE;
        voice_env_reset <= '0;
        for (int i = 0; i < N_VOICES; i++) begin
          v_state[i] <= V_FREE;
          v_rel[i]   <= '0;
        end
      end else begin
        // Sample-tick housekeeping runs in every FSM state.
        // NOTE: non-blocking assignments only; a later assignment to the same
        // register in this block (the commit below) deliberately overrides these.
        for (int i = 0; i < N_VOICES; i++) begin
          if (sample_tick && v_state[i] != V_FREE && v_age[i] != '1)
            v_age[i] <= v_age[i] + AGE_W'(1);
          if (v_state[i] == V_REL) begin
            if (v_rel[i] == '0)    v_state[i] <= V_FREE;
            else if (sample_tick)  v_rel[i]   <= v_rel[i] - REL_W'(1);
          end
          if (sample_tick) voice_env_reset[i] <= 1'b0;
        end

        case (fsm)
          S_IDLE: begin
            ready_q <= 1'b1;
            if (ev_valid && ready_q) begin
              ev_on_q    <= ev_note_on;
              ev_note_q  <= ev_note;
              ev_freq_q  <= ev_freq;
              ev_vel_q   <= ev_velocity;
              scan_idx   <= '0;
              best_class <= C_NONE;
              ready_q    <= 1'b0;
              fsm        <= S_SCAN;
            end
          end

          S_SCAN: begin
            if (cand_better) begin
              best_class <= cand_class;
              best_idx   <= scan_idx;
              best_age   <= v_age[scan_idx];
            end
            if (scan_idx == IDX_W'(N_VOICES - 1)) fsm      <= S_COMMIT;
            else                                  scan_idx <= scan_idx + IDX_W'(1);
          end

          S_COMMIT: begin
            if (best_class != C_NONE) begin
              if (ev_on_q) begin
                v_state[best_idx]         <= V_ON;
                v_note[best_idx]          <= ev_note_q;
                v_freq[best_idx]          <= ev_freq_q;
                v_vel[best_idx]           <= ev_vel_q;
                v_age[best_idx]           <= '0;
                v_rel[best_idx]           <= '0;
                voice_env_reset[best_idx] <= 1'b1;
              end else begin
                v_state[best_idx] <= V_REL;
                v_rel[best_idx]   <= REL_W'(RELEASE_TICKS);
              end
            end
            ready_q <= 1'b1;
            fsm     <= S_IDLE;
          end

          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule
